// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: controller state encoding and default bit timing.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEF = 868;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Received-byte FIFO: power-of-two depth, wrapping pointers, occupancy counter.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop & ~empty;
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);

    // Gate the head to zero when empty so stale storage never shows after reset.
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst && do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: input synchronizer, oversampling FSM with baud counter, and
// shift register feeding a small byte FIFO.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    rx_state_e   state;
    logic        rx_m;
    logic        rx_s;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        bit_end;
    logic        push;
    logic        pop;
    logic        full;
    logic        empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    assign bit_end  = (cnt == FULL_M1);
    // Good stop bit: the byte goes into the FIFO on the stop-sample edge itself.
    assign push     = en & (state == ST_STOP) & bit_end & rx_s;
    assign rx_valid = ~empty;
    assign pop      = rx_valid & rx_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= push & full & ~pop;
            if (!en) begin
                // Disable abandons any partial frame silently.
                state   <= ST_IDLE;
                cnt     <= '0;
                bit_idx <= '0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            state <= ST_START;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    ST_START: begin
                        if (cnt == HALF_M1) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            if (!rx_s) begin
                                state <= ST_DATA;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (bit_end) begin
                            cnt     <= '0;
                            shreg   <= {rx_s, shreg[7:1]};
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == 3'd7)
                                state <= ST_STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (bit_end) begin
                            cnt <= '0;
                            if (rx_s) begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state     <= ST_BREAK;
                                frame_err <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_BREAK: begin
                        // Wait out a held-low line so it cannot be taken as new start bits.
                        if (rx_s) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (shreg),
        .pop   (pop),
        .rdata (rx_data),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_rx_ctrl;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b1;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    int checks = 0;
    int failures = 0;

    int n_pop = 0, n_rise = 0, n_ferr = 0, n_ovr = 0, n_busy = 0;
    int b_pop, b_rise, b_ferr, b_ovr, b_busy;
    logic vld_d = 1'b0;
    logic [7:0] pop_log [1024];

    // Event monitor: sampled mid-cycle, ahead of the edge that acts on the values.
    always @(negedge clk) begin
        if (rst) begin
            if (frame_err) n_ferr++;
            if (overrun) n_ovr++;
            if (busy) n_busy++;
            if (rx_valid && !vld_d) n_rise++;
            if (rx_valid && rx_ready) begin
                pop_log[n_pop] = rx_data;
                n_pop++;
            end
            vld_d = rx_valid;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        b_pop = n_pop; b_rise = n_rise; b_ferr = n_ferr; b_ovr = n_ovr; b_busy = n_busy;
    endtask

    // mode 1: rx_ready high only for the stop-sample edge; 2: en low in data bit 4;
    // 3: rst low in data bit 4.
    task automatic send(input logic [7:0] d, input logic stop, input int mode);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            rx = fr[c / CPB];
            case (mode)
                1: rx_ready = (c == 154);
                2: en = !(c >= 88 && c <= 90);
                3: rst = !(c >= 88 && c <= 89);
                default: ;
            endcase
            @(posedge clk);
            #1;
        end
        en = 1'b1;
        rst = 1'b1;
    endtask

    initial begin
        idle(3);
        chk("rst_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_data", rx_data, 8'h00);
        rst = 1'b1;
        idle(5);

        rx_ready = 1'b1;
        snap();
        send(8'hA5, 1'b1, 0);
        idle(8);
        chk("a5_pops", n_pop - b_pop, 1);
        chk("a5_data", pop_log[b_pop], 8'hA5);
        chk("a5_rise", n_rise - b_rise, 1);
        chk("a5_ferr", n_ferr - b_ferr, 0);
        chk("a5_ovr", n_ovr - b_ovr, 0);

        snap();
        rx = 1'b0;
        idle(5);
        rx = 1'b1;
        idle(30);
        chk("glitch_busy_seen", (n_busy - b_busy) > 0, 1);
        chk("glitch_busy_end", busy, 0);
        chk("glitch_pops", n_pop - b_pop, 0);
        chk("glitch_rise", n_rise - b_rise, 0);
        chk("glitch_ferr", n_ferr - b_ferr, 0);

        snap();
        send(8'h3C, 1'b0, 0);
        idle(40);
        chk("ferr_pulse", n_ferr - b_ferr, 1);
        chk("ferr_no_valid", n_rise - b_rise, 0);
        chk("ferr_break_busy", busy, 1);
        rx = 1'b1;
        idle(8);
        send(8'h5A, 1'b1, 0);
        idle(8);
        chk("ferr_next_pops", n_pop - b_pop, 1);
        chk("ferr_next_data", pop_log[b_pop], 8'h5A);
        chk("ferr_once", n_ferr - b_ferr, 1);

        rx_ready = 1'b0;
        snap();
        for (int v = 1; v <= 5; v++) begin
            send(8'(v), 1'b1, 0);
            idle(4);
        end
        chk("ovr_pulse", n_ovr - b_ovr, 1);
        chk("ovr_valid", rx_valid, 1);
        rx_ready = 1'b1;
        idle(10);
        chk("ovr_pops", n_pop - b_pop, 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("ovr_data%0d", k), pop_log[b_pop + k], k + 1);
        chk("ovr_drained", rx_valid, 0);

        rx_ready = 1'b0;
        snap();
        for (int v = 0; v < 4; v++) begin
            send(8'(8'h10 + v), 1'b1, 0);
            idle(4);
        end
        send(8'h77, 1'b1, 1);
        idle(4);
        chk("fullpop_ovr", n_ovr - b_ovr, 0);
        rx_ready = 1'b1;
        idle(10);
        chk("fullpop_pops", n_pop - b_pop, 5);
        chk("fullpop_first", pop_log[b_pop], 8'h10);
        chk("fullpop_last", pop_log[n_pop - 1], 8'h77);

        for (int m = 2; m <= 3; m++) begin
            rx_ready = 1'b1;
            snap();
            send(8'hFF, 1'b1, m);
            idle(8);
            chk($sformatf("abort%0d_pops", m), n_pop - b_pop, 0);
            chk($sformatf("abort%0d_ferr", m), n_ferr - b_ferr, 0);
            chk($sformatf("abort%0d_ovr", m), n_ovr - b_ovr, 0);
            send(8'h12, 1'b1, 0);
            idle(8);
            chk($sformatf("abort%0d_next_pops", m), n_pop - b_pop, 1);
            chk($sformatf("abort%0d_next_data", m), pop_log[b_pop], 8'h12);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clocks per serial bit (legal range 4..65535).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of received-byte entries (power of two, 2..16).
REQ-003 The block SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: synchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1: receiver enable.
REQ-006 The block SHALL have port rx, input, 1: asynchronous serial line, idle high.
REQ-007 The block SHALL have port rx_data, output, 8: byte at the FIFO head.
REQ-008 The block SHALL have port rx_valid, output, 1: FIFO not empty.
REQ-009 The block SHALL have port rx_ready, input, 1: consumer accepts the head byte.
REQ-010 The block SHALL have port busy, output, 1: frame in progress (state not IDLE).
REQ-011 The block SHALL have port frame_err, output, 1: one-cycle pulse on a bad stop bit.
REQ-012 The block SHALL have port overrun, output, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; the synchronized value (rx_s) SHALL be the only line value used.
REQ-014 The controller FSM SHALL have five states: IDLE, START, DATA, STOP, BREAK.
REQ-015 The baud counter SHALL clear on every state entry and increment each cycle in START, DATA and STOP.
REQ-016 IDLE: when en=1 and rx_s=0, the FSM SHALL go to START.
REQ-017 START: at count CLKS_PER_BIT/2-1, the FSM SHALL go to DATA if rx_s=0; otherwise it SHALL return to IDLE as a glitch, with no outputs pulsed.
REQ-018 DATA: at count CLKS_PER_BIT-1, the FSM SHALL shift rx_s into the shift register LSB-first and clear the counter; after the 8th sample it SHALL go to STOP.
REQ-019 STOP: at count CLKS_PER_BIT-1 with rx_s=1, the FSM SHALL push the byte into the FIFO and go to IDLE.
REQ-020 STOP: at count CLKS_PER_BIT-1 with rx_s=0, the FSM SHALL pulse frame_err, discard the byte and go to BREAK.
REQ-021 BREAK: the FSM SHALL stay until rx_s=1, then go to IDLE; a line held low SHALL NOT produce further frames.
REQ-022 rx_valid SHALL rise on the cycle after the stop-bit sample edge when the FIFO was empty.
REQ-023 A pop SHALL occur iff rx_valid=1 and rx_ready=1; rx_data SHALL show the next entry on the following cycle.
REQ-024 When the FIFO is full and a push coincides with a pop, the push SHALL be accepted and overrun SHALL NOT pulse.
REQ-025 When the FIFO is full and a push occurs without a pop, the byte SHALL be dropped, overrun SHALL pulse, and FIFO contents SHALL stay unchanged.
REQ-026 Read and write pointers SHALL wrap modulo FIFO_DEPTH, with an occupancy counter of width clog2(FIFO_DEPTH)+1.
REQ-027 When en=0, the FSM SHALL go to IDLE on the next edge from any state, and any partial frame SHALL be discarded with no pulses.
REQ-028 When en=0, FIFO contents and the pop path SHALL remain operational.
REQ-029 frame_err and overrun SHALL never be asserted for more than one cycle per frame.

Reset
REQ-030 While rst=0 at a clock edge, the state SHALL be IDLE and the counter, shift register and FIFO pointers/count SHALL be 0.
REQ-031 While rst=0 at a clock edge, the synchronizer flops SHALL be 1.
REQ-032 While rst=0 at a clock edge, rx_valid, busy, frame_err and overrun SHALL be 0, and rx_data SHALL be 8'h00.
REQ-033 Reset asserted mid-frame SHALL abort the frame, and stored FIFO bytes SHALL be lost.
REQ-034 After reset release, the first start bit SHALL be detected only once rx_s=0, i.e. at least 2 cycles after a falling rx.

Structure
REQ-035 A shared package uart_pkg SHALL hold the FSM state encoding (3-bit) and the default CLKS_PER_BIT constant.
REQ-036 The FIFO SHALL be a separate sub-module uart_rx_fifo (8-bit, FIFO_DEPTH entries, push/pop/full/empty).
REQ-037 The FSM, baud counter, synchronizer and shift register SHALL reside in uart_rx_ctrl.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-038 Send 0xA5 with a valid stop bit and rx_ready=1: rx_valid SHALL pulse once, rx_data=0xA5, and frame_err and overrun SHALL stay 0.
REQ-039 Drive a 5-cycle low glitch on idle rx: busy SHALL rise, the FSM SHALL return to IDLE, and no byte or pulse SHALL result.
REQ-040 Send 0x3C with the stop bit low: frame_err SHALL pulse once, and rx_valid SHALL stay 0 until the line goes high and a new good frame arrives.
REQ-041 Send 0x01..0x05 with rx_ready=0: 4 entries SHALL be held, overrun SHALL pulse on 0x05, and pops SHALL return 0x01, 0x02, 0x03, 0x04.
REQ-042 With the FIFO full and rx_ready=1 exactly on the stop-sample cycle of 0x77: there SHALL be no overrun, and 0x77 SHALL be the last entry popped.
REQ-043 Deassert en, or pulse rst=0, during DATA bit 4 of 0xFF: there SHALL be no push and no pulses, and a following 0x12 SHALL be received correctly.
